z_read_scheduler: RTL and testbench

- Sequences the Z-test front end: accepts 2-pixel spans from the rasterizer and issues the Z read for each span to the Avalon-MM read port.
- Enqueues the span into the downstream read FIFO in the same cycle the read is accepted.
- Flow-controls the rasterizer so the read FIFO never overflows or wraps its used-word count.
- Reports busy/idle so the frame sequencer can flush before swapping buffers or changing Z mode.

---
 rtl/z_read_scheduler_pkg.sv | 19 +
 rtl/z_read_scheduler_outstanding_counter.sv | 30 +++
 rtl/z_read_scheduler.sv | 144 ++++++++++++++
 tb/tb_z_read_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_read_scheduler_pkg.sv
// Shared definitions for the Z-test read front end: span field widths,
// scheduler state encoding and read FIFO sizing defaults.
package z_read_scheduler_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int PIX_W  = 2;

    localparam int FIFO_DEPTH_DEF      = 32;
    localparam int FIFO_DEPTH_LOG2_DEF = 5;
    localparam int MAX_OUTSTANDING_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_PASS = 2'd2
    } state_t;

endpackage

// File: rtl/z_read_scheduler_outstanding_counter.sv
// Counts Z reads accepted by memory whose data has not yet returned.
module z_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign full = (count >= CNT_W'(MAX_OUTSTANDING));

    // A return strobe with nothing in flight means the memory side broke protocol.
    a_no_underflow : assert property (@(posedge clock) disable iff (!reset_n)
        dec |-> (count != '0));

endmodule

// File: rtl/z_read_scheduler.sv
// Accepts 2-pixel spans, issues their Z reads and enqueues each span into the
// downstream read FIFO in the cycle its read is accepted.
module z_read_scheduler
    import z_read_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
    parameter int FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       z_active,
    input  logic                       flush,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [ADDR_W-1:0]          pix_color_address,
    input  logic [DATA_W-1:0]          pix_color,
    input  logic [ADDR_W-1:0]          pix_z_address,
    input  logic [DATA_W-1:0]          pix_z,
    input  logic [PIX_W-1:0]           pix_active,
    output logic [ADDR_W-1:0]          read_address,
    output logic                       read_read,
    input  logic                       read_waitrequest,
    input  logic                       read_readdatavalid,
    input  logic [FIFO_DEPTH_LOG2-1:0] fifo_size,
    output logic                       enqueue,
    output logic [ADDR_W-1:0]          enq_color_address,
    output logic [DATA_W-1:0]          enq_color,
    output logic [ADDR_W-1:0]          enq_z_address,
    output logic [DATA_W-1:0]          enq_z,
    output logic [PIX_W-1:0]           enq_pixel_active,
    output logic                       busy,
    output logic                       flush_done
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [FIFO_DEPTH_LOG2:0] ROOM_LIMIT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH - 2);

    state_t                   state, state_nxt;
    logic                     run_p0;
    logic                     enq_p1;
    logic                     flush_pending;
    logic [CNT_W-1:0]         outstanding;
    logic                     cnt_full;
    logic [FIFO_DEPTH_LOG2:0] fill_sum;
    logic                     room;
    logic                     accept;
    logic                     drain_done;
    logic [ADDR_W-1:0]        lat_color_address;
    logic [DATA_W-1:0]        lat_color;
    logic [ADDR_W-1:0]        lat_z_address;
    logic [DATA_W-1:0]        lat_z;
    logic [PIX_W-1:0]         lat_pixel_active;

    // fifo_size lags our own enqueue by a cycle, so the last enqueue is added back in.
    assign fill_sum   = {1'b0, fifo_size} + (FIFO_DEPTH_LOG2 + 1)'(enq_p1);
    assign room       = (fill_sum < ROOM_LIMIT);
    assign accept     = pix_valid && pix_ready;
    assign drain_done = (state == ST_IDLE) && (outstanding == '0) && (fifo_size == '0) && !enq_p1;
    assign busy       = (state != ST_IDLE) || (outstanding != '0) || (fifo_size != '0)
                        || enq_p1 || flush_pending;

    z_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstanding (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (read_read && !read_waitrequest),
        .dec     (read_readdatavalid),
        .count   (outstanding),
        .full    (cnt_full)
    );

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        enqueue   = 1'b0;
        case (state)
            ST_IDLE: begin
                pix_ready = run_p0 && room && !flush_pending && (!z_active || !cnt_full);
                if (pix_valid && pix_ready) begin
                    state_nxt = z_active ? ST_READ : ST_PASS;
                end
            end
            ST_READ: begin
                // The FIFO entry must exist before the read data can come back.
                if (!read_waitrequest) begin
                    enqueue   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PASS: begin
                enqueue   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            run_p0            <= 1'b0;
            enq_p1            <= 1'b0;
            flush_pending     <= 1'b0;
            flush_done        <= 1'b0;
            read_read         <= 1'b0;
            read_address      <= '0;
            lat_color_address <= '0;
            lat_color         <= '0;
            lat_z_address     <= '0;
            lat_z             <= '0;
            lat_pixel_active  <= '0;
        end else begin
            state         <= state_nxt;
            run_p0        <= 1'b1;
            enq_p1        <= enqueue;
            flush_done    <= flush_pending && drain_done;
            // A repeated flush while one is pending folds into the same completion.
            flush_pending <= flush_pending ? !drain_done : flush;
            if (accept) begin
                lat_color_address <= pix_color_address;
                lat_color         <= pix_color;
                lat_z_address     <= pix_z_address;
                lat_z             <= pix_z;
                lat_pixel_active  <= pix_active;
            end
            if (accept && z_active) begin
                read_read    <= 1'b1;
                read_address <= pix_z_address;
            end else if (read_read && !read_waitrequest) begin
                read_read    <= 1'b0;
            end
        end
    end

    assign enq_color_address = lat_color_address;
    assign enq_color         = lat_color;
    assign enq_z_address     = lat_z_address;
    assign enq_z             = lat_z;
    assign enq_pixel_active  = lat_pixel_active;

endmodule

// File: tb/tb_z_read_scheduler.sv
// Directed bench for z_read_scheduler: Z reads, pass-through spans, FIFO room,
// outstanding limit, flush and mid-transaction reset.
module tb_z_read_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        z_active;
    logic        flush;
    logic        pix_valid;
    logic        pix_ready;
    logic [28:0] pix_color_address;
    logic [63:0] pix_color;
    logic [28:0] pix_z_address;
    logic [63:0] pix_z;
    logic [1:0]  pix_active;
    logic [28:0] read_address;
    logic        read_read;
    logic        read_waitrequest;
    logic        read_readdatavalid;
    logic [4:0]  fifo_size;
    logic        enqueue;
    logic [28:0] enq_color_address;
    logic [63:0] enq_color;
    logic [28:0] enq_z_address;
    logic [63:0] enq_z;
    logic [1:0]  enq_pixel_active;
    logic        busy;
    logic        flush_done;

    int n_asserts = 0;
    int n_fail    = 0;
    int acc_cnt;
    int rd_cnt;
    logic [63:0] exp_color;
    logic [28:0] exp_caddr;
    logic [1:0]  exp_act;

    always #5 clock = ~clock;

    z_read_scheduler dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .z_active           (z_active),
        .flush              (flush),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_color_address  (pix_color_address),
        .pix_color          (pix_color),
        .pix_z_address      (pix_z_address),
        .pix_z              (pix_z),
        .pix_active         (pix_active),
        .read_address       (read_address),
        .read_read          (read_read),
        .read_waitrequest   (read_waitrequest),
        .read_readdatavalid (read_readdatavalid),
        .fifo_size          (fifo_size),
        .enqueue            (enqueue),
        .enq_color_address  (enq_color_address),
        .enq_color          (enq_color),
        .enq_z_address      (enq_z_address),
        .enq_z              (enq_z),
        .enq_pixel_active   (enq_pixel_active),
        .busy               (busy),
        .flush_done         (flush_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; z_active = 1'b0; flush = 1'b0; pix_valid = 1'b0;
        pix_color_address = '0; pix_color = '0; pix_z_address = '0; pix_z = '0;
        pix_active = '0; read_waitrequest = 1'b0; read_readdatavalid = 1'b0; fifo_size = '0;
        cyc(); cyc();
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_read_read", read_read, 0);
        chk("rst_enqueue", enqueue, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_read_address", read_address, 0);
        reset_n = 1'b1;
        cyc();
        chk("ready_after_reset", pix_ready, 1);

        // Z read with three wait-state cycles
        z_active = 1'b1; pix_valid = 1'b1; read_waitrequest = 1'b1;
        pix_z_address = 29'h100; pix_color_address = 29'h0ABC;
        pix_color = 64'h1111_2222_3333_4444; pix_z = 64'h5555_6666_7777_8888; pix_active = 2'b10;
        #1;
        chk("zr_ready", pix_ready, 1);
        cyc();
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("zr_hold_read", read_read, 1);
            chk("zr_hold_addr", read_address, 29'h100);
            chk("zr_hold_noenq", enqueue, 0);
            cyc();
        end
        read_waitrequest = 1'b0;
        #1;
        chk("zr_read_4th", read_read, 1);
        chk("zr_enqueue", enqueue, 1);
        chk("zr_enq_zaddr", enq_z_address, 29'h100);
        chk("zr_enq_z", enq_z, 64'h5555_6666_7777_8888);
        chk("zr_enq_color", enq_color, 64'h1111_2222_3333_4444);
        chk("zr_enq_caddr", enq_color_address, 29'h0ABC);
        chk("zr_enq_act", enq_pixel_active, 2'b10);
        chk("zr_out0", dut.outstanding, 0);
        cyc();
        chk("zr_read_drop", read_read, 0);
        chk("zr_enq_once", enqueue, 0);
        chk("zr_out1", dut.outstanding, 1);
        chk("zr_busy", busy, 1);
        read_readdatavalid = 1'b1;
        cyc();
        read_readdatavalid = 1'b0;
        chk("zr_out_back0", dut.outstanding, 0);
        cyc();

        // Ten back-to-back pass-through spans
        z_active = 1'b0; pix_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pix_color_address = 29'h1000 + 29'(k);
            pix_color = {32'hC0DE_0000 + 32'(k), 32'h00FF_0000 + 32'(k)};
            pix_active = 2'(k);
            exp_caddr = 29'h1000 + 29'(k);
            exp_color = {32'hC0DE_0000 + 32'(k), 32'h00FF_0000 + 32'(k)};
            exp_act = 2'(k);
            #1;
            chk("pass_ready", pix_ready, 1);
            chk("pass_idle_noenq", enqueue, 0);
            cyc();
            chk("pass_enqueue", enqueue, 1);
            chk("pass_color", enq_color, exp_color);
            chk("pass_caddr", enq_color_address, exp_caddr);
            chk("pass_act", enq_pixel_active, exp_act);
            chk("pass_no_read", read_read, 0);
            cyc();
        end
        pix_valid = 1'b0;

        // FIFO room check
        fifo_size = 5'd30;
        #1;
        chk("room30_enq", pix_ready, 0);
        cyc();
        chk("room30", pix_ready, 0);
        chk("room_busy", busy, 1);
        fifo_size = 5'd29;
        #1;
        chk("room29", pix_ready, 1);
        pix_valid = 1'b1;
        cyc();
        pix_valid = 1'b0;
        chk("room_pass_enq", enqueue, 1);
        cyc();
        chk("room29_enq", pix_ready, 0);
        cyc();
        chk("room29_again", pix_ready, 1);
        fifo_size = 5'd0;
        cyc();

        // Outstanding limit with no returns
        z_active = 1'b1; read_waitrequest = 1'b0; pix_valid = 1'b1;
        acc_cnt = 0; rd_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (pix_valid && pix_ready) acc_cnt++;
            if (read_read && !read_waitrequest) rd_cnt++;
            cyc();
        end
        chk("lim_accepts", acc_cnt, 16);
        chk("lim_reads", rd_cnt, 16);
        chk("lim_out16", dut.outstanding, 16);
        chk("lim_ready0", pix_ready, 0);
        pix_valid = 1'b0;
        read_readdatavalid = 1'b1;
        #1;
        chk("lim_ready_still0", pix_ready, 0);
        cyc();
        chk("lim_out15", dut.outstanding, 15);
        chk("lim_ready1", pix_ready, 1);
        for (int i = 0; i < 12; i++) cyc();
        read_readdatavalid = 1'b0;
        chk("lim_out3", dut.outstanding, 3);

        // Flush with three reads outstanding
        flush = 1'b1; fifo_size = 5'd2;
        cyc();
        flush = 1'b0; pix_valid = 1'b1;
        #1;
        chk("fl_block", pix_ready, 0);
        chk("fl_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            read_readdatavalid = 1'b1;
            #1;
            chk("fl_wait_ret", flush_done, 0);
            chk("fl_no_read", read_read, 0);
            cyc();
        end
        read_readdatavalid = 1'b0;
        chk("fl_out0", dut.outstanding, 0);
        chk("fl_wait_fifo", flush_done, 0);
        chk("fl_busy_fifo", busy, 1);
        cyc();
        chk("fl_wait_fifo2", flush_done, 0);
        chk("fl_block2", pix_ready, 0);
        fifo_size = 5'd0; pix_valid = 1'b0;
        #1;
        chk("fl_pending_busy", busy, 1);
        cyc();
        chk("fl_done", flush_done, 1);
        chk("fl_busy_fall", busy, 0);
        cyc();
        chk("fl_done_once", flush_done, 0);

        // Flush while idle, repeated for two cycles
        flush = 1'b1;
        cyc();
        chk("fli_busy", busy, 1);
        cyc();
        flush = 1'b0;
        chk("fli_done", flush_done, 1);
        cyc();
        chk("fli_absorbed", flush_done, 0);
        cyc();
        chk("fli_absorbed2", flush_done, 0);
        chk("fli_idle", busy, 0);

        // Reset during READ with two reads outstanding
        z_active = 1'b1; pix_valid = 1'b1; read_waitrequest = 1'b0;
        pix_z_address = 29'h200;
        cyc(); cyc(); cyc(); cyc();
        read_waitrequest = 1'b1;
        cyc();
        pix_valid = 1'b0;
        chk("rr_read", read_read, 1);
        chk("rr_out2", dut.outstanding, 2);
        reset_n = 1'b0;
        #1;
        chk("rr_read0", read_read, 0);
        chk("rr_addr0", read_address, 0);
        chk("rr_enq0", enqueue, 0);
        chk("rr_ready0", pix_ready, 0);
        chk("rr_busy0", busy, 0);
        chk("rr_encz0", enq_z, 0);
        chk("rr_out0", dut.outstanding, 0);
        cyc();
        reset_n = 1'b1; read_waitrequest = 1'b0;
        cyc();
        pix_valid = 1'b1; pix_z_address = 29'h2A0;
        #1;
        chk("rr_ready_again", pix_ready, 1);
        cyc();
        pix_valid = 1'b0;
        chk("rr_new_read", read_read, 1);
        chk("rr_new_addr", read_address, 29'h2A0);
        chk("rr_new_enq", enqueue, 1);
        cyc();
        chk("rr_new_out1", dut.outstanding, 1);
        chk("rr_new_drop", read_read, 0);
        read_readdatavalid = 1'b1;
        cyc();
        read_readdatavalid = 1'b0;
        chk("rr_final_out0", dut.outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
